// File: rtl/priority_encoder_32_to_5_queued_if.sv
// Event-in / index-out bundle for the queued 32-to-5 priority encoder.
// The slave side is the encoder; the master side drives events and accepts indices.
interface priority_encoder_32_to_5_queued_if #(
    parameter int unsigned N = 32,
    parameter int unsigned W = $clog2(N)
);
    logic         ena;
    logic [N-1:0] in;
    logic         ready;
    logic [W-1:0] out;
    logic         valid;
    logic         busy;
    logic         dropped;

    modport master (
        output ena,
        output in,
        output ready,
        input  out,
        input  valid,
        input  busy,
        input  dropped
    );

    modport slave (
        input  ena,
        input  in,
        input  ready,
        output out,
        output valid,
        output busy,
        output dropped
    );
endinterface

// File: rtl/priority_encoder_32_to_5_queued.sv
// Queued priority encoder: folds N event lines into a sticky pending set and
// streams pending events out one index per handshake, lowest index first.
module priority_encoder_32_to_5_queued #(
    parameter int unsigned N = 32,
    parameter int unsigned W = $clog2(N)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    priority_encoder_32_to_5_queued_if.slave       bus_io
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic         dropped_q, dropped_d;

    logic [N-1:0] set_vec;
    logic [N-1:0] clr_onehot;
    logic [W-1:0] enc_idx;
    logic         slot_free;

    assign set_vec   = bus_io.ena ? bus_io.in : '0;
    assign slot_free = !valid_q || bus_io.ready;

    // Lowest set bit of pending; scanning downward lets the lowest index win.
    always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                enc_idx = W'(i);
            end
        end
    end

    // Next-state: load the output slot when free, then merge new events.
    always_comb begin
        out_d      = out_q;
        valid_d    = valid_q;
        clr_onehot = '0;
        if (slot_free) begin
            if (|pending_q) begin
                out_d               = enc_idx;
                valid_d             = 1'b1;
                clr_onehot[enc_idx] = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
        // A bit cleared by this load and set again in the same cycle is a new event.
        pending_d = (pending_q & ~clr_onehot) | set_vec;
        dropped_d = |(set_vec & pending_q & ~clr_onehot);
    end

    // State registers, discarded on asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus_io.out     = out_q;
    assign bus_io.valid   = valid_q;
    assign bus_io.busy    = (|pending_q) || valid_q;
    assign bus_io.dropped = dropped_q;

endmodule
